// File: rtl/cache_miss_arbiter_if.sv
// cache_miss_arbiter_if: miss requests, memory read/return and cache fill signals around the arbiter
interface cache_miss_arbiter_if #(parameter int WORDS = 8, parameter int ADDR_W = 16, parameter int DATA_W = 16);
  logic i_miss, d_miss, mem_data_valid, mem_rd_en, i_stall, d_stall;
  logic fill_i_we, fill_d_we, tag_i_we, tag_d_we, busy;
  logic [ADDR_W-1:0] i_miss_addr, d_miss_addr, mem_addr;
  logic [DATA_W-1:0] mem_data_in, fill_data;
  logic [$clog2(WORDS)-1:0] fill_word;
  modport slave (
    input i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data_in,
    output mem_rd_en, mem_addr, i_stall, d_stall, fill_i_we, fill_d_we, fill_word, fill_data,
    output tag_i_we, tag_d_we, busy
  );
  modport master (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_valid, mem_data_in,
    input mem_rd_en, mem_addr, i_stall, d_stall, fill_i_we, fill_d_we, fill_word, fill_data,
    input tag_i_we, tag_d_we, busy
  );
endinterface

// File: rtl/cache_miss_arbiter.sv
// cache_miss_arbiter: round-robin I/D miss arbitration, block read issue and cache fill steering
module cache_miss_arbiter #(
  parameter int WORDS = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input logic clk,
  input logic rst,
  cache_miss_arbiter_if.slave b
);
  localparam int LW = $clog2(WORDS);
  localparam int BW = ADDR_W - LW - 1;
  typedef enum logic [2:0] {IDLE, FILL_I, FILL_D, DONE_I, DONE_D} state_t;
  state_t state_q;
  logic last_d_q;
  logic [LW:0] req_q, resp_q;
  logic [BW-1:0] blk_q;
  logic filling, fill_d, req, ret, last, grant_d;
  assign filling = state_q == FILL_I || state_q == FILL_D;
  assign fill_d = state_q == FILL_D;
  assign req = filling && !req_q[LW];
  // a return with no outstanding request is an excess word and is dropped
  assign ret = filling && b.mem_data_valid && resp_q != req_q;
  assign last = ret && resp_q == (LW+1)'(WORDS - 1);
  assign grant_d = b.d_miss && (!b.i_miss || !last_d_q);
  assign b.mem_rd_en = req;
  assign b.mem_addr = req ? {blk_q, req_q[LW-1:0], 1'b0} : '0;
  assign b.fill_i_we = ret && !fill_d;
  assign b.fill_d_we = ret && fill_d;
  assign b.fill_word = resp_q[LW-1:0];
  assign b.fill_data = b.mem_data_in;
  assign b.tag_i_we = last && !fill_d;
  assign b.tag_d_we = last && fill_d;
  assign b.busy = state_q != IDLE;
  assign b.i_stall = (b.i_miss && state_q != DONE_I) || state_q == FILL_I;
  assign b.d_stall = (b.d_miss && state_q != DONE_D) || state_q == FILL_D;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_d_q <= 1'b0;
      req_q <= '0;
      resp_q <= '0;
      blk_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (b.i_miss || b.d_miss) begin
          state_q <= grant_d ? FILL_D : FILL_I;
          blk_q <= grant_d ? b.d_miss_addr[ADDR_W-1:LW+1] : b.i_miss_addr[ADDR_W-1:LW+1];
          req_q <= '0;
          resp_q <= '0;
        end
        FILL_I, FILL_D: begin
          if (req) req_q <= req_q + 1'b1;
          if (ret) resp_q <= resp_q + 1'b1;
          if (last) begin
            state_q <= fill_d ? DONE_D : DONE_I;
            last_d_q <= fill_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
